// File: rtl/mixed_radix_adder_stage.sv
// One-hot mixed-radix digit adder with a NULL/DATA registration stage.
// Optional modulo output with dual-rail carry, sticky illegal-code flag and token counter.
//
// state  | meaning
// S_NULL | register holds NULL (all-zero q_out/c_out), in_comp=0
// S_DATA | register holds a one-hot sum digit, in_comp=1
module mixed_radix_adder_stage #(
  parameter int RA   = 2,
  parameter int RB   = 3,
  parameter int MODR = 0,
  parameter int CW   = 8,
  localparam int OW  = (MODR == 0) ? RA + RB - 1 : MODR
) (
  input  logic          clk,
  input  logic          init,
  input  logic [RA-1:0] a_in,
  input  logic [RB-1:0] b_in,
  output logic          in_comp,
  input  logic          out_comp,
  output logic [OW-1:0] q_out,
  output logic [1:0]    c_out,
  output logic          err,
  output logic [CW-1:0] tok_cnt
);

  generate
    if (RA < 2 || RB < 2 || (MODR != 0 && RA + RB - 2 >= 2 * MODR)) begin : g_bad_param
      $error("mixed_radix_adder_stage: illegal RA/RB/MODR combination");
    end
  endgenerate

  typedef enum logic {S_NULL = 1'b0, S_DATA = 1'b1} state_t;

  state_t          state, state_next;
  logic [OW-1:0]   q_next, q_sum;
  logic [1:0]      c_next, carry;
  logic [CW-1:0]   tok_next;
  logic            err_next;
  logic            a_seen, a_multi, b_seen, b_multi;
  logic            illegal, complete, empty;
  int              a_idx, b_idx, sum, digit;

  always_comb begin
    a_seen  = 1'b0;
    a_multi = 1'b0;
    a_idx   = 0;
    b_seen  = 1'b0;
    b_multi = 1'b0;
    b_idx   = 0;
    for (int i = 0; i < RA; i++) begin
      if (a_in[i]) begin
        if (a_seen) a_multi = 1'b1;
        a_seen = 1'b1;
        a_idx  = i;
      end
    end
    for (int i = 0; i < RB; i++) begin
      if (b_in[i]) begin
        if (b_seen) b_multi = 1'b1;
        b_seen = 1'b1;
        b_idx  = i;
      end
    end
    illegal  = a_multi | b_multi;
    complete = a_seen & b_seen & ~illegal;
    empty    = ~a_seen & ~b_seen;

    // Legal MODR guarantees sum < 2*MODR, so one subtraction reduces it.
    sum = a_idx + b_idx;
    if (MODR != 0 && sum >= MODR) begin
      digit = sum - MODR;
      carry = 2'b10;
    end else begin
      digit = sum;
      carry = (MODR != 0) ? 2'b01 : 2'b00;
    end
    q_sum = '0;
    for (int i = 0; i < OW; i++) q_sum[i] = (digit == i);

    state_next = state;
    q_next     = q_out;
    c_next     = c_out;
    tok_next   = tok_cnt;
    err_next   = err | illegal;
    if (!illegal) begin
      case (state)
        S_NULL: if (!out_comp && complete) begin
          state_next = S_DATA;
          q_next     = q_sum;
          c_next     = carry;
          tok_next   = tok_cnt + CW'(1);
        end
        S_DATA: if (out_comp && empty) begin
          state_next = S_NULL;
          q_next     = '0;
          c_next     = 2'b00;
        end
        default: state_next = S_NULL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state   <= S_NULL;
      q_out   <= '0;
      c_out   <= 2'b00;
      err     <= 1'b0;
      tok_cnt <= '0;
    end else begin
      state   <= state_next;
      q_out   <= q_next;
      c_out   <= c_next;
      err     <= err_next;
      tok_cnt <= tok_next;
    end
  end

  assign in_comp = (state == S_DATA);

endmodule

// File: tb/tb_mixed_radix_adder_stage.sv
// Directed bench for mixed_radix_adder_stage: full-sum, modulo-3 and 2-bit-counter
// instances share one stimulus stream; expectations are hand-computed per step.
module tb_mixed_radix_adder_stage;

  logic       clk = 1'b0;
  logic       init;
  logic [1:0] a;
  logic [2:0] b;
  logic       out_comp;

  logic       ic0, ic3, icw;
  logic [3:0] q0, qw;
  logic [2:0] q3;
  logic [1:0] c0, c3, cw;
  logic       e0, e3, ew;
  logic [7:0] t0, t3;
  logic [1:0] tw;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mixed_radix_adder_stage #(.RA(2), .RB(3), .MODR(0), .CW(8)) u_full (
    .clk(clk), .init(init), .a_in(a), .b_in(b), .in_comp(ic0), .out_comp(out_comp),
    .q_out(q0), .c_out(c0), .err(e0), .tok_cnt(t0));

  mixed_radix_adder_stage #(.RA(2), .RB(3), .MODR(3), .CW(8)) u_mod (
    .clk(clk), .init(init), .a_in(a), .b_in(b), .in_comp(ic3), .out_comp(out_comp),
    .q_out(q3), .c_out(c3), .err(e3), .tok_cnt(t3));

  mixed_radix_adder_stage #(.RA(2), .RB(3), .MODR(0), .CW(2)) u_wrap (
    .clk(clk), .init(init), .a_in(a), .b_in(b), .in_comp(icw), .out_comp(out_comp),
    .q_out(qw), .c_out(cw), .err(ew), .tok_cnt(tw));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full-sum and modulo instances, with expected token counts.
  task automatic chk_all(input string tag, input logic [3:0] eq0, input logic [2:0] eq3,
                         input logic [1:0] ec3, input logic eic, input logic eerr,
                         input int etok);
    chk({tag, ".q0"},  32'(q0),  32'(eq0));
    chk({tag, ".ic0"}, 32'(ic0), 32'(eic));
    chk({tag, ".c0"},  32'(c0),  32'(0));
    chk({tag, ".e0"},  32'(e0),  32'(eerr));
    chk({tag, ".t0"},  32'(t0),  32'(etok & 8'hff));
    chk({tag, ".q3"},  32'(q3),  32'(eq3));
    chk({tag, ".c3"},  32'(c3),  32'(ec3));
    chk({tag, ".ic3"}, 32'(ic3), 32'(eic));
    chk({tag, ".tw"},  32'(tw),  32'(etok & 3));
  endtask

  initial begin
    init = 1'b1; a = '0; b = '0; out_comp = 1'b0;
    step();
    init = 1'b0;
    chk_all("reset", 4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 0);

    // 0+2=2
    a = 2'b01; b = 3'b100; out_comp = 1'b0;
    step();
    chk_all("t1_data", 4'b0100, 3'b100, 2'b01, 1'b1, 1'b0, 1);

    // DATA held while downstream asks for NULL but inputs are still DATA
    out_comp = 1'b1;
    step();
    step();
    chk_all("t2_hold", 4'b0100, 3'b100, 2'b01, 1'b1, 1'b0, 1);
    a = '0; b = '0;
    step();
    chk_all("t2_null", 4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 1);

    // 1+2=3: carry out of the modulo instance
    out_comp = 1'b0; a = 2'b10; b = 3'b100;
    step();
    chk_all("t3_carry", 4'b1000, 3'b001, 2'b10, 1'b1, 1'b0, 2);
    // new DATA with out_comp=0 while in S_DATA: no change
    a = 2'b01; b = 3'b001;
    step();
    chk_all("t3_stale", 4'b1000, 3'b001, 2'b10, 1'b1, 1'b0, 2);
    // inputs NULL but downstream still wants DATA: hold
    a = '0; b = '0;
    step();
    chk_all("t3_nullhold", 4'b1000, 3'b001, 2'b10, 1'b1, 1'b0, 2);
    out_comp = 1'b1;
    step();
    chk_all("t3_null", 4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 2);
    // 0+1=1
    out_comp = 1'b0; a = 2'b01; b = 3'b010;
    step();
    chk_all("t3_nocarry", 4'b0010, 3'b010, 2'b01, 1'b1, 1'b0, 3);
    out_comp = 1'b1; a = '0; b = '0;
    step();
    chk_all("t3_null2", 4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 3);

    // PARTIAL: only a present for 5 cycles
    out_comp = 1'b0; a = 2'b10; b = 3'b000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("t4_partial%0d", i), 4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 3);
    end
    b = 3'b001;
    step();
    chk_all("t4_complete", 4'b0010, 3'b010, 2'b01, 1'b1, 1'b0, 4);
    out_comp = 1'b1; a = '0; b = '0;
    step();
    chk_all("t4_null", 4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 4);

    // ILLEGAL b for one cycle
    out_comp = 1'b0; a = 2'b01; b = 3'b011;
    step();
    chk_all("t5_illegal", 4'b0000, 3'b000, 2'b00, 1'b0, 1'b1, 4);
    chk("t5_err_mod", 32'(e3), 32'(1));
    chk("t5_err_wrap", 32'(ew), 32'(1));
    // 1+1=2 legal token after the error; err must remain set
    a = 2'b10; b = 3'b010;
    step();
    chk_all("t5_resume", 4'b0100, 3'b100, 2'b01, 1'b1, 1'b1, 5);
    out_comp = 1'b1; a = '0; b = '0;
    step();
    chk_all("t5_null", 4'b0000, 3'b000, 2'b00, 1'b0, 1'b1, 5);

    // three more tokens: 2-bit counter returns to 0 on the fourth after its last wrap
    for (int k = 0; k < 3; k++) begin
      out_comp = 1'b0; a = 2'b10; b = 3'b100;
      step();
      chk_all($sformatf("t6_tok%0d", k), 4'b1000, 3'b001, 2'b10, 1'b1, 1'b1, 6 + k);
      out_comp = 1'b1; a = '0; b = '0;
      step();
      chk_all($sformatf("t6_null%0d", k), 4'b0000, 3'b000, 2'b00, 1'b0, 1'b1, 6 + k);
    end
    chk("t6_wrap_zero", 32'(tw), 32'(0));

    // reset mid-token
    out_comp = 1'b0; a = 2'b01; b = 3'b001;
    step();
    chk_all("t6_pre_init", 4'b0001, 3'b001, 2'b01, 1'b1, 1'b1, 9);
    init = 1'b1;
    step();
    init = 1'b0;
    chk_all("t6_init", 4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 0);
    chk("t6_init_err_w", 32'(ew), 32'(0));
    chk("t6_init_ic_w", 32'(icw), 32'(0));
    // inputs still DATA, out_comp=0: stage in S_NULL accepts a fresh token
    step();
    chk_all("t6_after_init", 4'b0001, 3'b001, 2'b01, 1'b1, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
